// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// A one-cycle spi_start strobe in IDLE latches data_send, drops chip-select
// and runs eight SCLK periods. MOSI is launched on SCLK falling edges, and the
// first bit is launched at the start edge. MISO is sampled on SCLK rising
// edges. At the eighth falling edge the byte is delivered and a coincident
// one-cycle send_done/rec_done pulse is issued.
//
// Handshake: spi_start is a request sampled on every rising sys_clk edge
// while idle. There is no ready output. A request made while a byte is in
// flight is dropped, not queued, and holding spi_start high produces
// back-to-back bytes separated by one idle cycle.
//
// All outputs are registered. Next values for the FSM and every register are
// computed in one combinational block, and one sequential block stores them.
module spi_master #(
  parameter int HALF_PERIOD = 4
) (
  input  logic       sys_clk,
  input  logic       sys_reset_n,
  input  logic       spi_start,
  input  logic [7:0] data_send,
  output logic [7:0] data_receive,
  output logic       send_done,
  output logic       rec_done,
  input  logic       spi_miso,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] half_cnt, half_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  // Only the seven bits still to be sent are kept. The MSB goes straight
  // onto spi_mosi at the start edge.
  logic [6:0]    tx_shift, tx_shift_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic [7:0]    data_receive_n;
  logic          sclk_n, cs_n_n, mosi_n, done_n;

  // Next-state and next-output logic. Every register holds by default.
  always_comb begin
    state_n        = state;
    half_cnt_n     = half_cnt;
    bit_cnt_n      = bit_cnt;
    tx_shift_n     = tx_shift;
    rx_shift_n     = rx_shift;
    data_receive_n = data_receive;
    sclk_n         = spi_sclk;
    cs_n_n         = spi_cs_n;
    mosi_n         = spi_mosi;
    done_n         = 1'b0;

    case (state)
      IDLE: begin
        sclk_n = 1'b0;
        cs_n_n = 1'b1;
        mosi_n = 1'b0;
        if (spi_start) begin
          tx_shift_n = data_send[6:0];
          cs_n_n     = 1'b0;
          mosi_n     = data_send[7];
          half_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = XFER;
        end
      end

      XFER: begin
        if (half_cnt == HALF_LAST) begin
          half_cnt_n = '0;
          if (!spi_sclk) begin
            // Rising SCLK edge: capture the slave's bit at the LSB.
            sclk_n     = 1'b1;
            rx_shift_n = {rx_shift[6:0], spi_miso};
          end else if (bit_cnt != 3'd7) begin
            // Falling SCLK edge: launch the next bit a half-period early.
            sclk_n     = 1'b0;
            mosi_n     = tx_shift[6];
            tx_shift_n = {tx_shift[5:0], 1'b0};
            bit_cnt_n  = bit_cnt + 3'd1;
          end else begin
            // Eighth falling edge: deliver the byte and return to idle.
            sclk_n         = 1'b0;
            cs_n_n         = 1'b1;
            mosi_n         = 1'b0;
            data_receive_n = rx_shift;
            done_n         = 1'b1;
            state_n        = IDLE;
          end
        end else begin
          half_cnt_n = half_cnt + CW'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state        <= IDLE;
      half_cnt     <= '0;
      bit_cnt      <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      data_receive <= 8'h00;
      spi_sclk     <= 1'b0;
      spi_cs_n     <= 1'b1;
      spi_mosi     <= 1'b0;
      send_done    <= 1'b0;
      rec_done     <= 1'b0;
    end else begin
      state        <= state_n;
      half_cnt     <= half_cnt_n;
      bit_cnt      <= bit_cnt_n;
      tx_shift     <= tx_shift_n;
      rx_shift     <= rx_shift_n;
      data_receive <= data_receive_n;
      spi_sclk     <= sclk_n;
      spi_cs_n     <= cs_n_n;
      spi_mosi     <= mosi_n;
      send_done    <= done_n;
      rec_done     <= done_n;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master. A slave model shifts a chosen byte onto MISO,
// and a monitor records SCLK rises, MOSI bits, chip-select edges and done
// pulses by sys_clk cycle number. Expected bytes and timings come from the
// mode-0 transfer rules, worked out here with plain arithmetic.
module tb_spi_master;

  localparam int HP  = 4;
  localparam int TMO = 40 * HP;

  logic       sys_clk = 1'b0;
  logic       sys_reset_n = 1'b0;
  logic       spi_start = 1'b0;
  logic [7:0] data_send = 8'h00;
  logic       spi_miso = 1'b0;
  logic [7:0] data_receive;
  logic       send_done, rec_done, spi_sclk, spi_cs_n, spi_mosi;

  spi_master #(.HALF_PERIOD(HP)) dut (
    .sys_clk      (sys_clk),
    .sys_reset_n  (sys_reset_n),
    .spi_start    (spi_start),
    .data_send    (data_send),
    .data_receive (data_receive),
    .send_done    (send_done),
    .rec_done     (rec_done),
    .spi_miso     (spi_miso),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // ---------------- slave model and monitor ----------------
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] slave_sh   = 8'h00;
  logic       prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
  int         last_mosi_chg = 0;
  int         rise_q[$], cs_rise_q[$], cs_fall_q[$], send_q[$], rec_q[$], setup_q[$];
  logic       mosi_q[$];
  logic [7:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int start_e = 0;

  always @(negedge sys_clk) begin
    if (spi_mosi !== prev_mosi) last_mosi_chg = cyc;
    if (spi_cs_n === 1'b0 && prev_cs === 1'b1) begin
      cs_fall_q.push_back(cyc);
      slave_sh = slave_byte;
      spi_miso = slave_sh[7];
    end
    if (spi_cs_n === 1'b1 && prev_cs === 1'b0) cs_rise_q.push_back(cyc);
    if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
      rise_q.push_back(cyc);
      mosi_q.push_back(spi_mosi);
      setup_q.push_back(cyc - last_mosi_chg);
    end
    if (spi_sclk === 1'b0 && prev_sclk === 1'b1 && spi_cs_n === 1'b0) begin
      slave_sh = {slave_sh[6:0], 1'b0};
      spi_miso = slave_sh[7];
    end
    if (send_done === 1'b1) send_q.push_back(cyc);
    if (rec_done === 1'b1) rec_q.push_back(cyc);
    prev_sclk = spi_sclk;
    prev_cs   = spi_cs_n;
    prev_mosi = spi_mosi;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    rise_q.delete(); cs_rise_q.delete(); cs_fall_q.delete();
    send_q.delete(); rec_q.delete(); setup_q.delete(); mosi_q.delete();
    exp_q.delete();
  endtask

  // Pulses spi_start for one cycle. On return start_e holds the accept edge.
  task automatic start_byte(input logic [7:0] d, input logic [7:0] s);
    @(negedge sys_clk); #1;
    slave_byte = s;
    data_send  = d;
    spi_start  = 1'b1;
    @(negedge sys_clk); #1;
    start_e   = cyc;
    spi_start = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    int t = 0;
    while (send_q.size() < n && t < TMO * n) begin
      @(negedge sys_clk); #1;
      t++;
    end
    ok = (send_q.size() >= n);
  endtask

  function automatic logic [7:0] mosi_byte(input int base);
    logic [7:0] b = 8'hxx;
    if (mosi_q.size() >= base + 8)
      for (int i = 0; i < 8; i++) b = {b[6:0], mosi_q[base + i]};
    return b;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad = 0;
    sys_reset_n = 1'b0;
    spi_start   = 1'b1;
    data_send   = 8'($urandom_range(0, 255));
    repeat (4) begin
      @(negedge sys_clk); #1;
      if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0 ||
          send_done !== 1'b0 || rec_done !== 1'b0 || data_receive !== 8'h00) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_values: %0d bad cycles, cs_n=%b sclk=%b mosi=%b dr=%h, required 1 0 0 00",
               bad, spi_cs_n, spi_sclk, spi_mosi, data_receive);
    end
    n_tests++;
    if (rise_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_sclk_idle: %0d sclk rises, required 0", rise_q.size());
    end
    spi_start = 1'b0;
    sys_reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    #1;
  endtask

  task automatic test_single();
    bit ok;
    int bad = 0;
    int min_setup = 1000;
    logic [7:0] got;
    clear_obs();
    exp_q.push_back(8'hAA);
    start_byte(8'hAA, 8'h5C);
    n_tests++;
    if (spi_cs_n !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cs_low: cs_n=%b one cycle after start, required 0", spi_cs_n);
    end
    wait_done(1, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_timeout: no done within %0d cycles", TMO);
    end
    repeat (4) @(negedge sys_clk);
    #1;
    n_tests++;
    if (rise_q.size() != 8) begin
      n_fail++;
      $display("FAIL single_rise_count: %0d, required 8", rise_q.size());
    end
    for (int k = 1; k <= 8; k++)
      if (k > rise_q.size() || rise_q[k-1] != start_e + (2*k - 1) * HP) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL single_rise_times: %0d rises off schedule (first at %0d, required %0d)",
               bad, (rise_q.size() > 0) ? rise_q[0] - start_e : -1, HP);
    end
    foreach (setup_q[i]) if (setup_q[i] < min_setup) min_setup = setup_q[i];
    n_tests++;
    if (min_setup < HP) begin
      n_fail++;
      $display("FAIL single_mosi_setup: min %0d cycles before rise, required >= %0d", min_setup, HP);
    end
    got = mosi_byte(0);
    n_tests++;
    if (got !== exp_q[0]) begin
      n_fail++;
      $display("FAIL single_mosi: got %h, required %h", got, exp_q[0]);
    end
    void'(exp_q.pop_front());
    n_tests++;
    if (cs_rise_q.size() != 1 || cs_rise_q[0] != start_e + 16 * HP) begin
      n_fail++;
      $display("FAIL single_cs_high: %0d rises, first at %0d, required 1 at %0d",
               cs_rise_q.size(), (cs_rise_q.size() > 0) ? cs_rise_q[0] - start_e : -1, 16 * HP);
    end
    n_tests++;
    if (send_q.size() != 1 || rec_q.size() != 1 ||
        send_q[0] != start_e + 16 * HP || rec_q[0] != start_e + 16 * HP) begin
      n_fail++;
      $display("FAIL single_done: send=%0d rec=%0d pulses, required one each at cycle %0d",
               send_q.size(), rec_q.size(), 16 * HP);
    end
    n_tests++;
    if (data_receive !== 8'h5C) begin
      n_fail++;
      $display("FAIL single_rx: got %h, required 5c", data_receive);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] tx_tab [4] = '{8'h00, 8'hFF, 8'h80, 8'h01};
    logic [7:0] sl_tab [4] = '{8'hFF, 8'h00, 8'h01, 8'h80};
    bit ok;
    logic [7:0] got;
    for (int i = 0; i < 4; i++) begin
      clear_obs();
      exp_q.push_back(tx_tab[i]);
      start_byte(tx_tab[i], sl_tab[i]);
      wait_done(1, ok);
      repeat (2) @(negedge sys_clk);
      #1;
      got = mosi_byte(0);
      n_tests++;
      if (!ok || got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL boundary_mosi[%0d]: got %h, required %h (done=%0b)", i, got, exp_q[0], ok);
      end
      n_tests++;
      if (data_receive !== sl_tab[i]) begin
        n_fail++;
        $display("FAIL boundary_rx[%0d]: got %h, required %h", i, data_receive, sl_tab[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] d, s, got;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(0, 255));
      clear_obs();
      exp_q.push_back(d);
      start_byte(d, s);
      // Disturb data_send mid-byte; the latched value must be what goes out.
      repeat ($urandom_range(1, 10 * HP)) @(negedge sys_clk);
      data_send = ~d;
      wait_done(1, ok);
      repeat (2) @(negedge sys_clk);
      #1;
      got = mosi_byte(0);
      n_tests++;
      if (!ok || got !== exp_q[0] || data_receive !== s || rise_q.size() != 8) begin
        n_fail++;
        $display("FAIL random[%0d]: mosi %h rx %h rises %0d, required %h %h 8",
                 i, got, data_receive, rise_q.size(), exp_q[0], s);
      end
    end
  endtask

  task automatic test_busy();
    bit ok;
    logic [7:0] s, got;
    s = 8'($urandom_range(1, 255));
    clear_obs();
    exp_q.push_back(8'hAA);
    start_byte(8'hAA, s);
    repeat (19) @(negedge sys_clk);
    #1;
    data_send = 8'h33;
    spi_start = 1'b1;
    @(negedge sys_clk); #1;
    spi_start = 1'b0;
    wait_done(1, ok);
    repeat (20) @(negedge sys_clk);
    #1;
    got = mosi_byte(0);
    n_tests++;
    if (!ok || send_q.size() != 1 || rec_q.size() != 1 || cs_fall_q.size() != 1) begin
      n_fail++;
      $display("FAIL busy_single_byte: send=%0d rec=%0d cs_falls=%0d, required 1 1 1",
               send_q.size(), rec_q.size(), cs_fall_q.size());
    end
    n_tests++;
    if (got !== exp_q[0] || rise_q.size() != 8 || data_receive !== s) begin
      n_fail++;
      $display("FAIL busy_stream: mosi %h rises %0d rx %h, required %h 8 %h",
               got, rise_q.size(), data_receive, exp_q[0], s);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t = 0;
    logic [7:0] s, g0, g1;
    s = 8'($urandom_range(0, 255));
    clear_obs();
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h81);
    @(negedge sys_clk); #1;
    slave_byte = s;
    data_send  = 8'h81;
    spi_start  = 1'b1;
    while (send_q.size() < 2 && t < 2 * TMO) begin
      @(negedge sys_clk); #1;
      t++;
    end
    spi_start = 1'b0;
    ok = (send_q.size() >= 2);
    repeat (4) @(negedge sys_clk);
    #1;
    n_tests++;
    if (!ok || send_q.size() != 2 || rec_q.size() != 2 || rise_q.size() != 16) begin
      n_fail++;
      $display("FAIL b2b_counts: send=%0d rec=%0d rises=%0d, required 2 2 16",
               send_q.size(), rec_q.size(), rise_q.size());
    end
    n_tests++;
    if (cs_fall_q.size() != 2 || cs_rise_q.size() < 1 || cs_fall_q[1] - cs_rise_q[0] != 1) begin
      n_fail++;
      $display("FAIL b2b_cs_gap: falls=%0d gap=%0d, required 2 falls gap 1", cs_fall_q.size(),
               (cs_fall_q.size() > 1 && cs_rise_q.size() > 0) ? cs_fall_q[1] - cs_rise_q[0] : -1);
    end
    n_tests++;
    if (send_q.size() < 2 || send_q[1] - send_q[0] != 16 * HP + 1) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0d cycles between dones, required %0d",
               (send_q.size() > 1) ? send_q[1] - send_q[0] : -1, 16 * HP + 1);
    end
    g0 = mosi_byte(0);
    g1 = mosi_byte(8);
    n_tests++;
    if (g0 !== exp_q[0] || g1 !== exp_q[1] || data_receive !== s) begin
      n_fail++;
      $display("FAIL b2b_data: mosi %h %h rx %h, required %h %h %h",
               g0, g1, data_receive, exp_q[0], exp_q[1], s);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] s, got;
    clear_obs();
    start_byte(8'h3C, 8'($urandom_range(0, 255)));
    repeat (30) @(negedge sys_clk);
    #2;
    sys_reset_n = 1'b0;
    #1;
    n_tests++;
    if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0 ||
        send_done !== 1'b0 || rec_done !== 1'b0 || data_receive !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_async: cs_n=%b sclk=%b mosi=%b sd=%b rd=%b dr=%h, required 1 0 0 0 0 00",
               spi_cs_n, spi_sclk, spi_mosi, send_done, rec_done, data_receive);
    end
    repeat (3) @(negedge sys_clk);
    #1;
    sys_reset_n = 1'b1;
    repeat (20 * HP) @(negedge sys_clk);
    #1;
    n_tests++;
    if (send_q.size() != 0 || rec_q.size() != 0 || spi_cs_n !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_no_done: send=%0d rec=%0d cs_n=%b, required 0 0 1",
               send_q.size(), rec_q.size(), spi_cs_n);
    end
    s = 8'($urandom_range(0, 255));
    clear_obs();
    exp_q.push_back(8'h0F);
    start_byte(8'h0F, s);
    wait_done(1, ok);
    repeat (2) @(negedge sys_clk);
    #1;
    got = mosi_byte(0);
    n_tests++;
    if (!ok || got !== exp_q[0] || data_receive !== s || send_q.size() != 1 || rise_q.size() != 8) begin
      n_fail++;
      $display("FAIL midreset_recover: mosi %h rx %h dones %0d rises %0d, required %h %h 1 8",
               got, data_receive, send_q.size(), rise_q.size(), exp_q[0], s);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_random();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
